conv5x5_mac: RTL and testbench
==============================

// Module: conv5x5_mac
// PURPOSE
//  Serial multiply-accumulate engine for one 5x5 convolution window: takes 25 pixel/weight
//  pairs over a valid/ready stream, accumulates, arithmetic-shifts the sum, and presents an
//  O_W-bit signed result. Sits directly upstream of the saturation stage; o_data feeds its
//  19-bit i_data, and saturation then clips to 16 bits.
// PARAMETERS
//  D_W    8   signed pixel width
//  K_W    8   signed weight width
//  TAPS   25  pairs per window (5x5)
//  SHIFT  2   arithmetic right shift applied to the final sum (>=1)
//  O_W    19  output width; must equal D_W+K_W+5-SHIFT (ACC_W = D_W+K_W+5 = 21)
// PORTS
//  i_clk      in   1      clock; all state on the rising edge
//  i_rst      in   1      synchronous, active-high reset
//  i_clear    in   1      synchronous abort of the current window
//  i_valid    in   1      pixel/weight pair valid
//  o_ready    out  1      engine accepts a pair this cycle
//  i_pixel    in   D_W    signed pixel
//  i_weight   in   K_W    signed weight
//  o_valid    out  1      result valid; held until i_ready
//  i_ready    in   1      downstream (saturation/writeback) accepts the result
//  o_data     out  O_W    signed result = sum(pixel*weight) >>> SHIFT
//  o_busy     out  1      high while at least one pair of the window is accumulated
// BEHAVIOUR
//  - Accept: a pair is consumed iff i_valid && o_ready at the clock edge.
//  - Product: full-precision signed D_W+K_W bits, sign-extended to ACC_W. No overflow is
//    possible for TAPS<=32.
//  - FSM:
//    - IDLE: cnt=0, o_ready=1. An accepted pair loads acc=product and cnt=1 (no add of a
//      stale acc), then -> ACC.
//    - ACC: o_ready=1. An accepted pair does acc+=product and cnt++. If the accepted pair
//      is #TAPS (cnt==TAPS-1), register o_data=(acc+product)>>>SHIFT, o_valid=1, -> HOLD.
//    - HOLD: o_ready=0, o_valid=1, o_data stable. On i_ready: o_valid=0, -> IDLE. A new
//      pair can be accepted the cycle after the handshake.
//  - Latency: o_valid rises 1 cycle after the 25th accept. Minimum throughput is one
//    window per TAPS+1 cycles, with i_ready tied high.
//  - Gaps: i_valid low in ACC stalls; acc and cnt hold.
//  - i_clear: in IDLE/ACC, next state is IDLE with cnt=0. A pair offered the same cycle is
//    discarded, so clear wins. In HOLD, i_clear is ignored and the result is still delivered.
//  - Shift: arithmetic (sign-preserving); truncation is toward -inf unless the option
//    below is compiled in.
//  - Reset (any state, mid-window included): state=IDLE, cnt=0, acc=0, o_valid=0, o_data=0,
//    o_busy=0. o_ready=1 the cycle after reset deasserts, and 0 while i_rst is high.
//  - o_busy = (state==ACC) || (state==HOLD).
// CONFIGURATION
//  CONV_MAC_ROUND_EN defined: adds 1<<(SHIFT-1) to the final sum before the shift
//    (round-half-up). The adder is ACC_W+1 wide, so there is no wrap.
//  Not defined: plain truncating shift and no extra adder.
// TESTING
//  1. 25 pairs of pixel=2, weight=1, i_ready=1 -> o_valid 1 cycle after the last accept;
//     o_data=12 (50>>>2). With CONV_MAC_ROUND_EN, o_data=13.
//  2. 25 pairs of pixel=-128, weight=127 -> o_data=-101600 (-406400>>>2). 25 pairs of
//     -128*-128 -> o_data=102400.
//  3. Backpressure: i_ready=0 for 10 cycles after o_valid -> o_data/o_valid stable,
//     o_ready=0, no pair accepted. Then i_ready=1 -> o_valid drops the next cycle.
//  4. i_valid toggled randomly 50% over a window of pixel=1, weight=1 -> o_data=6, exactly
//     25 accepts counted.
//  5. 10 pairs accepted, then i_clear with i_valid=1 in the same cycle, then 25 pairs of
//     1*1 -> o_data=6, not 8. Repeat with i_rst instead of i_clear -> same result, and
//     outputs are 0 during reset.
//  6. Back-to-back windows with i_ready=1 -> second o_valid exactly TAPS+1 cycles after the
//     first.

Source files
------------

// File: rtl/conv5x5_mac.sv
// Serial 5x5 convolution MAC: accumulates TAPS pixel*weight pairs and emits (sum >>> SHIFT).
// Define CONV_MAC_ROUND_EN to add round-half-up (1 << (SHIFT-1)) before the final shift.
module conv5x5_mac #(
  parameter int D_W   = 8,
  parameter int K_W   = 8,
  parameter int TAPS  = 25,
  parameter int SHIFT = 2,
  parameter int O_W   = 19
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [D_W-1:0] i_pixel,
  input  logic [K_W-1:0] i_weight,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [O_W-1:0] o_data,
  output logic           o_busy
);

  localparam int P_W   = D_W + K_W;
  localparam int ACC_W = D_W + K_W + 5;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [O_W-1:0]           data_q, data_d;
  logic                     valid_q, valid_d;

  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [O_W-1:0]           result;
  logic                     accept;

  assign prod     = P_W'($signed(i_pixel)) * P_W'($signed(i_weight));
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;

`ifdef CONV_MAC_ROUND_EN
  localparam int R_W = ACC_W + 1;
  logic signed [R_W-1:0] rsum;
  // One guard bit keeps the rounding increment from wrapping a near-max sum.
  assign rsum   = {sum[ACC_W-1], sum} + R_W'(1 << (SHIFT - 1));
  assign result = rsum[SHIFT +: O_W];
`else
  assign result = sum[SHIFT +: O_W];
`endif

  assign o_ready = !i_rst && (state_q != S_HOLD);
  assign accept  = i_valid && o_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          cnt_d = '0;
        end else if (accept) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (i_clear) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          acc_d = sum;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            data_d  = result;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_conv5x5_mac.sv
// Self-checking bench for conv5x5_mac: fixed-window table, handshake corner cases and
// random windows checked against an arithmetic reference (sum, optional round, floor divide).
module tb_conv5x5_mac;

  localparam int D_W = 8, K_W = 8, TAPS = 25, SHIFT = 2, O_W = 19;

  logic           clk = 1'b0;
  logic           i_rst, i_clear, i_valid, i_ready;
  logic [D_W-1:0] i_pixel;
  logic [K_W-1:0] i_weight;
  logic           o_ready, o_valid, o_busy;
  logic [O_W-1:0] o_data;

  always #5 clk = ~clk;

  conv5x5_mac #(.D_W(D_W), .K_W(K_W), .TAPS(TAPS), .SHIFT(SHIFT), .O_W(O_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_pixel(i_pixel), .i_weight(i_weight), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int px[TAPS];
  int wt[TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int w;
    int exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: exact integer sum, optional half-up bias, then floor division by 2^SHIFT.
  function automatic int model(input int n);
    int s = 0;
    int d = 1 << SHIFT;
    int q;
    for (int i = 0; i < n; i++) s += px[i] * wt[i];
`ifdef CONV_MAC_ROUND_EN
    s += d / 2;
`endif
    q = s / d;
    if (s < 0 && q * d != s) q--;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int p, input int w);
    for (int i = 0; i < TAPS; i++) begin
      px[i] = p;
      wt[i] = w;
    end
  endtask

  task automatic feed(input int n, input bit gaps, output int last_cyc);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 2000) begin
      i_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_pixel  = D_W'(px[k]);
      i_weight = K_W'(wt[k]);
      #1;
      if (i_valid && o_ready) begin
        if (k == TAPS - 1) check("valid_before_last", int'(o_valid), 0);
        k++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    i_valid  = 1'b0;
    last_cyc = cyc;
    if (k < n) check("feed_timeout", k, n);
  endtask

  task automatic expect_result(input string name, input int exp);
    check({name, "_valid"}, int'(o_valid), 1);
    check({name, "_data"}, $signed(o_data), exp);
    check({name, "_ready"}, int'(o_ready), 0);
    check({name, "_busy"}, int'(o_busy), 1);
  endtask

  task automatic handshake(input string name);
    i_ready = 1'b1;
    tick();
    check({name, "_drop"}, int'(o_valid), 0);
    check({name, "_idle"}, int'(o_busy), 0);
  endtask

  initial begin
    int c1, c2, lc, exp;
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_pixel = '0; i_weight = '0;

    repeat (3) tick();
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_ready), 0);
    i_rst = 1'b0;
    tick();
    check("post_rst_ready", int'(o_ready), 1);

    vecs[0] = '{p: 2,    w: 1,    exp: 12};
    vecs[1] = '{p: -128, w: 127,  exp: -101600};
    vecs[2] = '{p: -128, w: -128, exp: 102400};
    vecs[3] = '{p: 1,    w: 1,    exp: 6};
    vecs[4] = '{p: -1,   w: 1,    exp: -7};
    vecs[5] = '{p: 3,    w: -5,   exp: -94};
`ifdef CONV_MAC_ROUND_EN
    vecs[0].exp = 13;
    vecs[4].exp = -6;
`endif
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].p, vecs[v].w);
      feed(TAPS, 1'b0, lc);
      expect_result("table", vecs[v].exp);
      handshake("table");
    end

    // Backpressure: result must hold and no pair may slip in while stalled.
    fill(2, 3);
    exp = model(TAPS);
    i_ready = 1'b0;
    feed(TAPS, 1'b0, lc);
    expect_result("bp", exp);
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", int'(o_valid), 1);
      check("bp_hold_data", $signed(o_data), exp);
      check("bp_hold_ready", int'(o_ready), 0);
    end
    i_valid = 1'b0;
    handshake("bp");

    fill(1, 1);
    feed(TAPS, 1'b1, lc);
    expect_result("gaps", 6);
    handshake("gaps");

    feed(10, 1'b0, lc);
    check("clr_busy_before", int'(o_busy), 1);
    i_clear = 1'b1; i_valid = 1'b1;
    tick();
    i_clear = 1'b0; i_valid = 1'b0;
    check("clr_busy_after", int'(o_busy), 0);
    feed(TAPS, 1'b0, lc);
    expect_result("clr", 6);
    handshake("clr");

    feed(10, 1'b0, lc);
    i_rst = 1'b1; i_valid = 1'b1;
    #1;
    check("rst_mid_ready", int'(o_ready), 0);
    tick();
    check("rst_mid_valid", int'(o_valid), 0);
    check("rst_mid_data", int'(o_data), 0);
    check("rst_mid_busy", int'(o_busy), 0);
    tick();
    i_rst = 1'b0; i_valid = 1'b0;
    feed(TAPS, 1'b0, lc);
    expect_result("rstwin", 6);
    handshake("rstwin");

    fill(2, 1);
    exp = model(TAPS);
    i_ready = 1'b1;
    feed(TAPS, 1'b0, c1);
    expect_result("b2b1", exp);
    feed(TAPS, 1'b0, c2);
    expect_result("b2b2", exp);
    check("b2b_spacing", c2 - c1, TAPS + 1);
    handshake("b2b");

    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < TAPS; i++) begin
        px[i] = int'($urandom_range(0, 255)) - 128;
        wt[i] = int'($urandom_range(0, 255)) - 128;
      end
      i_ready = 1'b0;
      feed(TAPS, 1'b1, lc);
      repeat ($urandom_range(0, 3)) tick();
      expect_result("rand", model(TAPS));
      handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
